// File: rtl/riscv_hpc_bank.sv
// Performance-counter bank for the RISC-V core. It counts instruction classes,
// retirement, taken branches, stall cycles and external events. On overflow a
// counter either wraps or saturates. Overflow flags are sticky and can raise an
// interrupt. The read port has registered data.
module riscv_hpc_bank #(
  parameter int CNT_W    = 32,
  parameter int NUM_EXT  = 4,
  parameter int SATURATE = 0,
  localparam int NUM_CNT = 12 + NUM_EXT,
  localparam int ADDR_W  = $clog2(NUM_CNT),
  localparam int EXT_W   = (NUM_EXT > 0) ? NUM_EXT : 1
) (
  input  logic                clk,
  input  logic                rst_ni,
  input  logic                req_inst_valid,
  input  logic [31:0]         req_inst_opcode,
  input  logic                req_inst_retired,
  input  logic                req_inst_branch,
  input  logic                req_branch_taken,
  input  logic                stall_by_ALU,
  input  logic                stall_by_MEM,
  input  logic [EXT_W-1:0]    ext_evt_i,
  input  logic                freeze_i,
  input  logic [NUM_CNT-1:0]  inhibit_i,
  input  logic                clear_i,
  input  logic                wr_en_i,
  input  logic [ADDR_W-1:0]   wr_addr_i,
  input  logic [CNT_W-1:0]    wr_data_i,
  input  logic                rd_en_i,
  input  logic [ADDR_W-1:0]   rd_addr_i,
  output logic [CNT_W-1:0]    rd_data_o,
  output logic                rd_valid_o,
  output logic [NUM_CNT-1:0]  ovf_o,
  input  logic [NUM_CNT-1:0]  ovf_clr_i,
  input  logic [NUM_CNT-1:0]  irq_en_i,
  output logic                irq_o
);

  // Only the major opcode field takes part in instruction-class decoding.
  logic unused_opcode_hi;
  assign unused_opcode_hi = ^req_inst_opcode[31:7];

  // This function returns the value after one increment. An all-ones counter
  // wraps to zero, or holds at all-ones when SATURATE is set.
  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
    if (&v) return (SATURATE != 0) ? v : '0;
    else    return v + CNT_W'(1);
  endfunction

  logic [NUM_CNT-1:0] evt;
  logic [6:0]         opc;
  logic               is_r, is_i, is_s, is_b, is_u, is_j;

  logic [CNT_W-1:0]   cnt_q [NUM_CNT];
  logic [CNT_W-1:0]   cnt_d [NUM_CNT];
  logic [NUM_CNT-1:0] ovf_q, ovf_d, ovf_set;
  logic [CNT_W-1:0]   rd_data_q, rd_data_d;
  logic               rd_valid_q;
  logic               irq_q;

  // Decode the raw event for each counter index in this cycle.
  always_comb begin
    evt  = '0;
    opc  = req_inst_opcode[6:0];
    is_r = (opc == 7'b0110011);
    is_i = (opc == 7'b1100111) || (opc == 7'b0000011) || (opc == 7'b0010011);
    is_s = (opc == 7'b0100011);
    is_b = (opc == 7'b1100011);
    is_u = (opc == 7'b0110111) || (opc == 7'b0010111);
    is_j = (opc == 7'b1101111);
    evt[0]  = 1'b1;
    evt[1]  = req_inst_valid & req_inst_retired;
    evt[2]  = req_inst_valid & is_r;
    evt[3]  = req_inst_valid & is_i;
    evt[4]  = req_inst_valid & is_s;
    evt[5]  = req_inst_valid & is_b;
    evt[6]  = req_inst_valid & is_u;
    evt[7]  = req_inst_valid & is_j;
    evt[8]  = req_inst_valid & ~(is_r | is_i | is_s | is_b | is_u | is_j);
    evt[9]  = req_inst_valid & req_inst_branch & req_branch_taken;
    evt[10] = stall_by_ALU;
    evt[11] = stall_by_MEM;
    for (int k = 0; k < NUM_EXT; k++) evt[12+k] = ext_evt_i[k];
  end

  // Compute the next value of each counter and overflow flag.
  // Clear has the highest priority, then preload, then increment.
  always_comb begin
    ovf_set = '0;
    ovf_d   = ovf_q;
    for (int n = 0; n < NUM_CNT; n++) begin
      cnt_d[n] = cnt_q[n];
      if (clear_i) begin
        cnt_d[n] = '0;
      end else if (wr_en_i && (wr_addr_i == ADDR_W'(n))) begin
        cnt_d[n] = wr_data_i;
      end else if (evt[n] && !freeze_i && !inhibit_i[n]) begin
        cnt_d[n]   = cnt_inc(cnt_q[n]);
        ovf_set[n] = &cnt_q[n];
      end
      if (clear_i)           ovf_d[n] = 1'b0;
      else if (ovf_set[n])   ovf_d[n] = 1'b1;
      else if (ovf_clr_i[n]) ovf_d[n] = 1'b0;
    end
  end

  // Read mux. An index outside the bank returns zero.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en_i) begin
      if (int'(rd_addr_i) < NUM_CNT) rd_data_d = cnt_q[rd_addr_i];
      else                           rd_data_d = '0;
    end
  end

  // State registers: counters, flags, read port and interrupt.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int n = 0; n < NUM_CNT; n++) cnt_q[n] <= '0;
      ovf_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      for (int n = 0; n < NUM_CNT; n++) cnt_q[n] <= cnt_d[n];
      ovf_q      <= ovf_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_en_i;
      irq_q      <= |(ovf_q & irq_en_i);
    end
  end

  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;
  assign ovf_o      = ovf_q;
  assign irq_o      = irq_q;

endmodule

// File: tb/tb_riscv_hpc_bank.sv
// Scoreboard bench for riscv_hpc_bank. One wrapping instance and one
// saturating instance share the same stimulus.
module tb_riscv_hpc_bank;

  localparam int CNT_W   = 32;
  localparam int NUM_EXT = 3;
  localparam int NUM_CNT = 12 + NUM_EXT;
  localparam int ADDR_W  = $clog2(NUM_CNT);

  logic clk = 1'b0;
  logic rst_n;
  logic valid, retired, branch, taken, alu, mem;
  logic [31:0] opcode;
  logic [NUM_EXT-1:0] ext;
  logic freeze, clear, wr_en, rd_en;
  logic [NUM_CNT-1:0] inhibit, ovf_clr, irq_en;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [CNT_W-1:0] wr_data;

  logic [CNT_W-1:0] rd_data0, rd_data1;
  logic rd_valid0, rd_valid1, irq0, irq1;
  logic [NUM_CNT-1:0] ovf0, ovf1;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [CNT_W-1:0] e0;
    logic [CNT_W-1:0] e1;
    int a;
  } exp_t;
  exp_t sb[$];

  logic [CNT_W-1:0] cyc0;
  logic [CNT_W-1:0] saved;

  always #5 clk = ~clk;

  riscv_hpc_bank #(.CNT_W(CNT_W), .NUM_EXT(NUM_EXT), .SATURATE(0)) u_wrap (
    .clk(clk), .rst_ni(rst_n), .req_inst_valid(valid), .req_inst_opcode(opcode),
    .req_inst_retired(retired), .req_inst_branch(branch), .req_branch_taken(taken),
    .stall_by_ALU(alu), .stall_by_MEM(mem), .ext_evt_i(ext), .freeze_i(freeze),
    .inhibit_i(inhibit), .clear_i(clear), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
    .wr_data_i(wr_data), .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rd_data0),
    .rd_valid_o(rd_valid0), .ovf_o(ovf0), .ovf_clr_i(ovf_clr), .irq_en_i(irq_en),
    .irq_o(irq0));

  riscv_hpc_bank #(.CNT_W(CNT_W), .NUM_EXT(NUM_EXT), .SATURATE(1)) u_sat (
    .clk(clk), .rst_ni(rst_n), .req_inst_valid(valid), .req_inst_opcode(opcode),
    .req_inst_retired(retired), .req_inst_branch(branch), .req_branch_taken(taken),
    .stall_by_ALU(alu), .stall_by_MEM(mem), .ext_evt_i(ext), .freeze_i(freeze),
    .inhibit_i(inhibit), .clear_i(clear), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
    .wr_data_i(wr_data), .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rd_data1),
    .rd_valid_o(rd_valid1), .ovf_o(ovf1), .ovf_clr_i(ovf_clr), .irq_en_i(irq_en),
    .irq_o(irq1));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // The reference cycle counter counts every unfrozen cycle. Clear and reset
  // set it back to zero. The bench never preloads or inhibits counter 0.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)      cyc0 <= '0;
    else if (clear)  cyc0 <= '0;
    else if (!freeze) cyc0 <= cyc0 + 1;
  end

  // Pop the scoreboard entry whenever the read port presents data.
  always @(negedge clk) begin
    if (rst_n && rd_valid0) begin
      if (sb.size() == 0) begin
        chk("rd_spurious", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk($sformatf("rd_wrap[%0d]", e.a), rd_data0, e.e0);
        chk($sformatf("rd_sat[%0d]", e.a), rd_data1, e.e1);
        chk("rd_valid_sat", rd_valid1, 1);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic rd(input int a, input logic [CNT_W-1:0] e0, input logic [CNT_W-1:0] e1);
    exp_t e;
    e.e0 = e0; e.e1 = e1; e.a = a;
    rd_en = 1'b1; rd_addr = ADDR_W'(a);
    sb.push_back(e);
    tick();
    rd_en = 1'b0;
  endtask

  task automatic wr(input int a, input logic [CNT_W-1:0] d);
    wr_en = 1'b1; wr_addr = ADDR_W'(a); wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic inst(input logic [6:0] opc);
    valid = 1'b1; opcode = {25'd0, opc};
    tick();
    valid = 1'b0;
  endtask

  initial begin
    logic [6:0] opcs [7];
    opcs = '{7'b0110011, 7'b0000011, 7'b0100011, 7'b1100011,
             7'b0010111, 7'b1101111, 7'b1110011};
    rst_n = 1'b0; valid = 0; retired = 0; branch = 0; taken = 0; alu = 0; mem = 0;
    opcode = '0; ext = '0; freeze = 0; clear = 0; wr_en = 0; rd_en = 0;
    inhibit = '0; ovf_clr = '0; irq_en = '0; wr_addr = '0; rd_addr = '0; wr_data = '0;
    repeat (3) tick();
    chk("rst_rd_data", rd_data0, 0);
    chk("rst_rd_valid", rd_valid0, 0);
    chk("rst_ovf", ovf0, 0);
    chk("rst_irq", irq0, 0);
    rst_n = 1'b1;
    tick();

    // One instruction of each class, all retired.
    retired = 1'b1;
    for (int i = 0; i < 7; i++) inst(opcs[i]);
    retired = 1'b0;
    for (int c = 2; c <= 8; c++) rd(c, 1, 1);
    rd(1, 7, 7);
    rd(0, cyc0, cyc0);
    rd(9, 0, 0);

    // Overflow on counter 2: the wrapping instance wraps, the saturating one holds.
    irq_en = '0; irq_en[2] = 1'b1;
    wr(2, 32'hFFFF_FFFE);
    inst(7'b0110011);
    chk("preload_ones_no_ovf", ovf0[2], 0);
    inst(7'b0110011);
    chk("ovf_wrap", ovf0[2], 1);
    chk("ovf_sat", ovf1[2], 1);
    chk("irq_not_yet", irq0, 0);
    tick();
    chk("irq_wrap", irq0, 1);
    chk("irq_sat", irq1, 1);
    rd(2, 32'h0, 32'hFFFF_FFFF);

    // An overflow and a flag clear in the same cycle leave the flag set.
    wr(5, 32'hFFFF_FFFF);
    chk("ovf5_preload", ovf0[5], 0);
    ovf_clr[5] = 1'b1;
    inst(7'b1100011);
    ovf_clr = '0;
    chk("ovf_set_beats_clr", ovf0[5], 1);
    ovf_clr[2] = 1'b1;
    tick();
    ovf_clr = '0;
    chk("ovf_w1c", ovf0[2], 0);
    chk("irq_lags_ovf", irq0, 1);
    tick();
    chk("irq_dropped", irq0, 0);

    // Freeze with a memory stall: counting stops, preload still applies.
    freeze = 1'b1; mem = 1'b1;
    saved = cyc0;
    repeat (4) tick();
    rd(11, 0, 0);
    wr(11, 5);
    repeat (3) tick();
    rd(0, saved, saved);
    rd(11, 5, 5);
    freeze = 1'b0; mem = 1'b0;

    // A preload beats an increment, and a clear beats both.
    valid = 1'b1; opcode = 32'h13;
    wr(3, 100);
    valid = 1'b0;
    rd(3, 100, 100);
    valid = 1'b1; opcode = 32'h13; clear = 1'b1;
    wr(3, 100);
    valid = 1'b0; clear = 1'b0;
    chk("clear_ovf", ovf0, 0);
    rd(3, 0, 0);
    rd(0, cyc0, cyc0);

    // Per-counter inhibit, taken branch and external events.
    inhibit[7] = 1'b1;
    inst(7'b1101111);
    inhibit = '0;
    branch = 1'b1; taken = 1'b1;
    inst(7'b1100011);
    branch = 1'b0; taken = 1'b0;
    ext[2] = 1'b1; alu = 1'b1;
    tick();
    ext = '0; alu = 1'b0;
    rd(7, 0, 0);
    rd(8, 0, 0);
    rd(9, 1, 1);
    rd(5, 1, 1);
    rd(10, 1, 1);
    rd(14, 1, 1);
    rd(12, 0, 0);

    // The read-valid pulse lasts one cycle, the data holds, and an
    // out-of-range index reads zero.
    saved = cyc0;
    rd(0, saved, saved);
    tick();
    chk("rd_valid_pulse", rd_valid0, 0);
    chk("rd_data_hold", rd_data0, saved);
    rd(NUM_CNT, 0, 0);

    // An asynchronous reset while a flag and the interrupt are active.
    irq_en = '0; irq_en[4] = 1'b1;
    wr(4, 32'hFFFF_FFFF);
    inst(7'b0100011);
    tick();
    chk("pre_rst_irq", irq0, 1);
    rd(0, cyc0, cyc0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rd_data", rd_data0, 0);
    chk("arst_ovf", ovf0, 0);
    chk("arst_irq", irq0, 0);
    chk("arst_sat_ovf", ovf1, 0);
    chk("arst_sat_irq", irq1, 0);
    tick();
    rst_n = 1'b1;
    irq_en = '0;
    tick();
    rd(4, 0, 0);
    rd(0, cyc0, cyc0);

    for (int i = 0; i < 10 && sb.size() != 0; i++) tick();
    chk("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/riscv_hpc_bank.md
Name: riscv_hpc_bank

Overview:
Parametrised performance-counter bank for the RISC-V core; next generation of the single-purpose instruction-type counter. Counts instruction classes, retirement, taken branches, stall cycles and NUM_EXT external events in CNT_W-bit counters. Supports wrap or saturate mode, freeze, per-counter inhibit, software preload/clear, sticky overflow flags with interrupt, and a registered read port. Sits beside the pipeline controller, fed by its req_* request signals.

Parameters:
CNT_W, 32, counter width in bits (legal 8..64)
NUM_EXT, 4, number of external event inputs (legal 0..16)
SATURATE, 0, 0 = wrap to zero on overflow, 1 = hold at all-ones
NUM_CNT, 12+NUM_EXT, derived; total counters
ADDR_W, clog2(NUM_CNT), derived; index width

Ports:
clk  in  1  clock
rst_ni  in  1  asynchronous active-low reset
req_inst_valid  in  1  instruction event valid this cycle
req_inst_opcode  in  32  instruction word; bits [6:0] decoded
req_inst_retired  in  1  qualifies instret
req_inst_branch  in  1  instruction is a branch
req_branch_taken  in  1  branch taken
stall_by_ALU  in  1  ALU stall cycle
stall_by_MEM  in  1  memory stall cycle
ext_evt_i  in  NUM_EXT  external single-cycle events
freeze_i  in  1  inhibit all increments
inhibit_i  in  NUM_CNT  per-counter increment inhibit
clear_i  in  1  synchronous clear of all counters and flags
wr_en_i  in  1  preload strobe
wr_addr_i  in  ADDR_W  preload index
wr_data_i  in  CNT_W  preload value
rd_en_i  in  1  read strobe
rd_addr_i  in  ADDR_W  read index
rd_data_o  out  CNT_W  registered read data
rd_valid_o  out  1  read data valid
ovf_o  out  NUM_CNT  sticky overflow flags
ovf_clr_i  in  NUM_CNT  write-1-to-clear overflow flags
irq_en_i  in  NUM_CNT  overflow interrupt enables
irq_o  out  1  registered OR of (ovf & irq_en)

Behaviour:
- Reset (rst_ni low, async): all counters, ovf_o, rd_data_o, rd_valid_o, irq_o = 0. Asserting mid-operation discards everything immediately.
- Index map (increment condition, sampled each clk):
  0 cycle: every cycle. 1 instret: valid & retired.
  2 R (0110011), 3 I (1100111/0000011/0010011), 4 S (0100011), 5 B (1100011), 6 U (0110111/0010111), 7 J (1101111): valid & opcode match.
  8 other: valid & no class above matches (SYSTEM, FENCE, illegal).
  9 branch-taken: valid & branch & taken. 10 ALU stall: stall_by_ALU. 11 MEM stall: stall_by_MEM.
  12+k: ext_evt_i[k].
- Exactly one of 2..8 increments per valid instruction.
- Increment suppressed when freeze_i or inhibit_i[n]; +1 per cycle maximum.
- Per-counter priority: clear_i > write (wr_en_i & wr_addr_i==n) > increment. Write/clear work while frozen. wr_addr_i >= NUM_CNT ignored.
- Overflow: increment when counter == all-ones. SATURATE=0: wraps to 0; SATURATE=1: holds all-ones. Both set ovf_o[n] next cycle. Preload to all-ones does not set ovf.
- ovf_o[n]: set on overflow, cleared by ovf_clr_i[n] or clear_i; set wins over ovf_clr_i in same cycle; clear_i wins over set.
- irq_o = registered |(ovf_o & irq_en_i); one cycle after ovf_o changes.
- Read: rd_en_i at cycle t -> rd_data_o/rd_valid_o at t+1, value is counter state before cycle-t update. rd_addr_i >= NUM_CNT returns 0 with rd_valid_o=1. rd_valid_o is a 1-cycle pulse; rd_data_o holds last value otherwise.

Test Plan:
- Reset, then valid with opcodes 0110011,0000011,0100011,1100011,0010111,1101111,1110011 one per cycle, retired=1 -> read counters 2..8 = 1 each, counter 1 = 7, counter 0 = cycle count.
- Preload counter 2 = 0xFFFF_FFFE, two R-type: SATURATE=0 -> 0x0, ovf_o[2]=1, with irq_en_i[2]=1 irq_o=1 one cycle later; SATURATE=1 -> 0xFFFF_FFFF, ovf_o[2]=1.
- freeze_i=1 for 10 cycles with stall_by_MEM=1 -> counters 0 and 11 unchanged; write to counter 11 = 5 during freeze -> reads 5.
- Same cycle: wr_en_i to counter 3 = 100 and I-type valid -> 100; add clear_i -> 0. ovf set and ovf_clr_i same cycle -> flag stays 1.
- rd_en_i addr 0 at t -> rd_valid_o pulse at t+1 with pre-update value; rd_addr_i = NUM_CNT -> data 0.
- Assert rst_ni low mid-count with ovf/irq set -> all outputs 0 immediately, before next clk edge.
